pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core. It replaces fixed-field stage latches such as ID/EX, EX/MEM and MEM/WB with one block that adds a valid/ready handshake, flush, clean bubbles and a stall counter. Each instance carries one control bundle and one data bundle between adjacent stages. Each stage boundary instantiates it with its own bundle widths.

## Interface
- DATA_W, 32: width of the datapath bundle (ALU result, store data, targets, write-register number, packed by the caller)
- CTRL_W, 8: width of the control bundle (RegWrite, MemRead, MemWrite, Branch, Jump, MemtoReg, ...)
- CNT_W, 16: width of the stall counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming entries this cycle
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  this block accepts an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream consumes the entry this cycle
- out_ctrl  out  CTRL_W  control bundle; forced to 0 whenever out_valid=0
- out_data  out  DATA_W  data bundle; holds its last value when out_valid=0
- occupancy  out  2  number of held entries (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- An input transfer (in fire) occurs when in_valid=1 and in_ready=1. An output transfer (out fire) occurs when out_valid=1 and out_ready=1.
- Storage is a main register M, which drives the outputs, and a skid register S. The state is EMPTY, ONE or FULL. occupancy is 0, 1 or 2 respectively.
- EMPTY: in fire loads M and moves to ONE.
- ONE, with both in fire and out fire: M loads the input and the state stays ONE.
- ONE, with in fire only: S loads the input and the state moves to FULL.
- ONE, with out fire only: the state moves to EMPTY.
- FULL: in_ready=0. Out fire copies S into M and moves to ONE.
- Priority order: rst, then flush, then normal transfer.
- flush: the state becomes EMPTY and out_ctrl becomes 0. Any input presented in the flush cycle is dropped, even if in_valid=1. out_data is not cleared.
- Bubble rule: out_ctrl is gated to 0 whenever out_valid=0, so a bubble never asserts RegWrite or MemWrite downstream.
- stall_cnt increments by 1 in every cycle where out_valid=1 and out_ready=0. It holds at 2^CNT_W-1 once it reaches that value. It is cleared only by rst; flush does not clear it.
- Ordering is strictly FIFO. An entry is never duplicated or lost, except on flush.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1. All inputs are ignored while rst=1.
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- Throughput is 1 entry per cycle when out_ready is held at 1.
- In skid mode, in_ready is a register output: in_ready = (state != FULL). No combinational path exists from out_ready to in_ready.
- Raising flush or rst mid-stream takes effect at the next edge. in_ready is 1 in the following cycle.

## Configuration
- PIPE_STAGE_SKID_EN defined: the 2-entry skid behaviour described above, with registered in_ready.
- PIPE_STAGE_SKID_EN undefined:
  - S and the FULL state are not built, and occupancy never exceeds 1.
  - in_ready = ~out_valid | out_ready, which is combinational.
  - Transfers, flush, bubble gating, stall_cnt and latency are otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - the state enum: PS_EMPTY=0, PS_ONE=1, PS_FULL=2;
  - the default widths DATA_W_DEF=32, CTRL_W_DEF=8, CNT_W_DEF=16.
- Sub-module pipe_sat_counter is a CNT_W-bit saturating up-counter with synchronous clear. It implements stall_cnt.

## Test plan
- Reset, then stream 8 entries (data=1..8, ctrl=0x01) with out_ready=1. Required: outputs appear in order, one cycle late, one per cycle, and occupancy never exceeds 1.
- Accept data=0xA then 0xB with out_ready=0 (skid mode). Required: occupancy=2, in_ready=0, and 0xA is held on out_data. Then raise out_ready: 0xA and 0xB leave in order, and in_ready returns to 1.
- Assert flush while occupancy=2 and in_valid=1 with data=0xC. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xC never appears on the outputs.
- Hold out_valid=1 and out_ready=0 for 20 cycles with CNT_W=4. Required: stall_cnt reads 15 and holds at 15. A flush leaves it at 15; rst clears it to 0.
- Build with PIPE_STAGE_SKID_EN undefined, hold out_valid=1, and toggle out_ready. Required: in_ready follows out_ready in the same cycle, and occupancy never reaches 2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: the holding-state
// encoding, default bundle widths and a helper that turns a state into an
// entry count.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Encoding is chosen so the state value equals the number of held entries.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  // Number of entries held in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    logic [1:0] occ;
    case (s)
      PS_EMPTY: occ = 2'd0;
      PS_ONE:   occ = 2'd1;
      PS_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear. Once the count reaches the
// all-ones value it stays there until cleared.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count qualifying cycles, sticking at the top value; clear wins over inc.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// flush, bubble gating of the control bundle and a saturating stall counter.
//
// Build option: define PIPE_STAGE_SKID_EN to get a two-entry skid buffer
// (main register M plus skid register S) whose in_ready comes straight from
// a flop. Without it only M exists and in_ready is ~out_valid | out_ready.
//
// M always drives out_data; out_ctrl is forced to zero whenever no entry is
// held so a bubble can never assert a write enable downstream. out_data is
// deliberately left holding its last value on a bubble or a flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              in_fire;
  logic              out_fire;
  logic              stall;

  assign out_valid = (state != PS_EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = state_occupancy(state);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign stall    = out_valid & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              in_ready_q;

  // in_ready is a flop tracking "not FULL", so out_ready never reaches it
  // combinationally.
  assign in_ready = in_ready_q;

  // Two-entry holding FSM: M feeds the outputs, S catches the entry that
  // arrives while downstream is stalled; flush drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PS_EMPTY;
      m_ctrl     <= '0;
      m_data     <= '0;
      s_ctrl     <= '0;
      s_data     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= PS_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
            state  <= PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (in_fire) begin
            s_ctrl     <= in_ctrl;
            s_data     <= in_data;
            state      <= PS_FULL;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state <= PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            m_ctrl     <= s_ctrl;
            m_data     <= s_data;
            state      <= PS_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= PS_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`else

  // Single-entry mode: accept whenever the held entry is empty or leaving.
  assign in_ready = ~out_valid | out_ready;

  // Single-entry holding FSM; an accept while ONE always coincides with the
  // held entry leaving, so M is simply overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PS_EMPTY;
      m_ctrl <= '0;
      m_data <= '0;
    end else if (flush) begin
      state <= PS_EMPTY;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
            state  <= PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (out_fire) begin
            state <= PS_EMPTY;
          end
        end
        default: begin
          state <= PS_EMPTY;
        end
      endcase
    end
  end

`endif

  // Stall cycles are counted independently of flush; only rst clears them.
  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .clr  (rst),
    .inc  (stall),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table plus a few
// hand-written multi-cycle sequences. Expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              exp_valid;
    logic [CTRL_W-1:0] exp_ctrl;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        exp_occ;
    logic              exp_in_ready;
    logic [CNT_W-1:0]  exp_stall;
  } vec_t;

  vec_t vecs[$];

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs(input logic r, input logic f, input logic iv,
                              input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                              input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle 1 ns past it.
  task automatic apply_stimulus(input logic r, input logic f, input logic iv,
                                input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                input logic ordy);
    drive_inputs(r, f, iv, c, d, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic f, input logic iv,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic ev, input logic [CTRL_W-1:0] ec,
                         input logic [DATA_W-1:0] ed, input logic [1:0] eo,
                         input logic eir, input logic [CNT_W-1:0] es);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.in_ctrl = c; v.in_data = d;
    v.out_ready = ordy; v.exp_valid = ev; v.exp_ctrl = ec; v.exp_data = ed;
    v.exp_occ = eo; v.exp_in_ready = eir; v.exp_stall = es;
    vecs.push_back(v);
  endtask

  initial begin
    logic [DATA_W-1:0] exp_data;
    int                exp_stall;

    drive_inputs(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    // Streaming: reset, 8 entries back to back, then drain.
    add_vec(1, 0, 0, 8'h00, 32'h0, 1,  0, 8'h00, 32'h0, 2'd0, 1, 4'd0);
    for (int k = 1; k <= 8; k++)
      add_vec(0, 0, 1, 8'h01, 32'(k), 1,  1, 8'h01, 32'(k), 2'd1, 1, 4'd0);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1,  0, 8'h00, 32'h8, 2'd0, 1, 4'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Skid fill, blocked input, drain in order, flush while FULL.
    add_vec(1, 0, 0, 8'h00, 32'h0, 0,  0, 8'h00, 32'h0, 2'd0, 1, 4'd0);
    add_vec(0, 0, 1, 8'h01, 32'hA, 0,  1, 8'h01, 32'hA, 2'd1, 1, 4'd0);
    add_vec(0, 0, 1, 8'h02, 32'hB, 0,  1, 8'h01, 32'hA, 2'd2, 0, 4'd1);
    add_vec(0, 0, 1, 8'h04, 32'hD, 0,  1, 8'h01, 32'hA, 2'd2, 0, 4'd2);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1,  1, 8'h02, 32'hB, 2'd1, 1, 4'd2);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1,  0, 8'h00, 32'hB, 2'd0, 1, 4'd2);
    add_vec(0, 0, 1, 8'h01, 32'hA, 0,  1, 8'h01, 32'hA, 2'd1, 1, 4'd2);
    add_vec(0, 0, 1, 8'h02, 32'hB, 0,  1, 8'h01, 32'hA, 2'd2, 0, 4'd3);
    add_vec(0, 1, 1, 8'h08, 32'hC, 0,  0, 8'h00, 32'hA, 2'd0, 1, 4'd4);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1,  0, 8'h00, 32'hA, 2'd0, 1, 4'd4);
    add_vec(0, 0, 1, 8'h01, 32'hE, 1,  1, 8'h01, 32'hE, 2'd1, 1, 4'd4);
    add_vec(0, 0, 1, 8'h02, 32'hF, 1,  1, 8'h02, 32'hF, 2'd1, 1, 4'd4);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1,  0, 8'h00, 32'hF, 2'd0, 1, 4'd4);
`else
    // Single entry: blocked input, pass-through replace, flush drops input.
    add_vec(1, 0, 0, 8'h00, 32'h0, 0,  0, 8'h00, 32'h0, 2'd0, 1, 4'd0);
    add_vec(0, 0, 1, 8'h01, 32'hA, 0,  1, 8'h01, 32'hA, 2'd1, 0, 4'd0);
    add_vec(0, 0, 1, 8'h02, 32'hB, 0,  1, 8'h01, 32'hA, 2'd1, 0, 4'd1);
    add_vec(0, 0, 1, 8'h02, 32'hB, 1,  1, 8'h02, 32'hB, 2'd1, 1, 4'd1);
    add_vec(0, 1, 1, 8'h08, 32'hC, 0,  0, 8'h00, 32'hB, 2'd0, 1, 4'd2);
    add_vec(0, 0, 0, 8'h00, 32'h0, 0,  0, 8'h00, 32'hB, 2'd0, 1, 4'd2);
    add_vec(0, 0, 1, 8'h04, 32'hE, 1,  1, 8'h04, 32'hE, 2'd1, 1, 4'd2);
    add_vec(0, 0, 0, 8'h00, 32'h0, 1,  0, 8'h00, 32'hE, 2'd0, 1, 4'd2);
`endif

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].flush, vecs[i].in_valid,
                     vecs[i].in_ctrl, vecs[i].in_data, vecs[i].out_ready);
      check_output($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check_output($sformatf("row%0d.out_ctrl", i),  32'(out_ctrl),  32'(vecs[i].exp_ctrl));
      check_output($sformatf("row%0d.out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check_output($sformatf("row%0d.occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      check_output($sformatf("row%0d.in_ready", i),  32'(in_ready),  32'(vecs[i].exp_in_ready));
      check_output($sformatf("row%0d.stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
    end

    // Stall counter saturation, survives flush, cleared by rst.
    apply_stimulus(1, 0, 0, 8'h00, 32'h0, 0);
    check_output("sat.reset_cnt", 32'(stall_cnt), 32'd0);
    apply_stimulus(0, 0, 1, 8'h03, 32'h55, 0);
    check_output("sat.load_valid", 32'(out_valid), 32'd1);
    check_output("sat.load_data", 32'(out_data), 32'h55);
`ifdef PIPE_STAGE_SKID_EN
    check_output("sat.load_in_ready", 32'(in_ready), 32'd1);
`else
    check_output("sat.load_in_ready", 32'(in_ready), 32'd0);
`endif
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 0, 0, 8'h00, 32'h0, 0);
      exp_stall = (i + 1 > 15) ? 15 : i + 1;
      check_output($sformatf("sat.cnt%0d", i), 32'(stall_cnt), 32'(exp_stall));
      check_output($sformatf("sat.occ%0d", i), 32'(occupancy), 32'd1);
    end
    apply_stimulus(0, 1, 0, 8'h00, 32'h0, 0);
    check_output("sat.flush_valid", 32'(out_valid), 32'd0);
    check_output("sat.flush_ctrl", 32'(out_ctrl), 32'd0);
    check_output("sat.flush_data", 32'(out_data), 32'h55);
    check_output("sat.flush_cnt", 32'(stall_cnt), 32'd15);
    apply_stimulus(0, 0, 0, 8'h00, 32'h0, 0);
    check_output("sat.idle_cnt", 32'(stall_cnt), 32'd15);
    apply_stimulus(1, 0, 0, 8'h00, 32'h0, 0);
    check_output("sat.rst_cnt", 32'(stall_cnt), 32'd0);
    check_output("sat.rst_data", 32'(out_data), 32'h0);

`ifdef PIPE_STAGE_SKID_EN
    // in_ready is registered: raising out_ready while FULL does not free it
    // until the following edge.
    apply_stimulus(0, 0, 1, 8'h01, 32'hA, 0);
    apply_stimulus(0, 0, 1, 8'h02, 32'hB, 0);
    check_output("skid.full_occ", 32'(occupancy), 32'd2);
    drive_inputs(0, 0, 0, 8'h00, 32'h0, 1);
    #1;
    check_output("skid.same_cycle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("skid.next_in_ready", 32'(in_ready), 32'd1);
    check_output("skid.next_data", 32'(out_data), 32'hB);
    check_output("skid.next_occ", 32'(occupancy), 32'd1);
    drive_inputs(0, 0, 0, 8'h00, 32'h0, 0);
    #1;
    check_output("skid.hold_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
`else
    // in_ready follows out_ready within the cycle while an entry is held.
    apply_stimulus(0, 0, 1, 8'h01, 32'h2F, 0);
    exp_data = 32'h2F;
    for (int i = 0; i < 8; i++) begin
      drive_inputs(0, 0, 1, 8'h01, 32'h30 + 32'(i), (i % 2) == 1);
      #1;
      check_output($sformatf("tog%0d.in_ready", i), 32'(in_ready), 32'((i % 2) == 1));
      @(posedge clk);
      #1;
      if ((i % 2) == 1) exp_data = 32'h30 + 32'(i);
      check_output($sformatf("tog%0d.data", i), 32'(out_data), exp_data);
      check_output($sformatf("tog%0d.occ", i), 32'(occupancy), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
